// File: rtl/riscv_pkg.sv
// riscv_pkg: constants shared by the fetch path.
//   NOP_INST     canonical RISC-V NOP (addi x0, x0, 0)
//   rom_state_t  boot-loader / run-mode state of inst_rom
//   OPCODE_*     major opcode field values used by the PC register
package riscv_pkg;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic {
    LOAD = 1'b0,
    RUN  = 1'b1
  } rom_state_t;

  localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
  localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
  localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
  localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
  localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
  localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
  localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPCODE_OP     = 7'b0110011;

endpackage

// File: rtl/inst_rom_ram.sv
// inst_ram: DEPTH x 32 storage with one synchronous write port and one
// synchronous read port. No reset so that it maps onto block RAM.
//   clk    clock
//   we     write enable
//   waddr  write word address
//   wdata  write data
//   raddr  read word address (sampled every cycle)
//   rdata  read data, valid the cycle after raddr is presented
module inst_ram #(
  parameter int unsigned DEPTH = 256,
  parameter int unsigned AW    = 8
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    rdata <= mem_q[raddr];
  end

endmodule

// File: rtl/inst_rom.sv
// inst_rom: instruction-side responder with boot-time program loading.
// After reset (BOOT_LOAD=1) it accepts loader words into the array while
// holding the core in reset, then switches to RUN and answers fetches with
// a fixed one-cycle latency.
//   clk, rst                   clock, asynchronous active-high reset
//   load_valid/data/last       loader word stream
//   load_ready                 a loader word is accepted this cycle
//   load_count                 words written since reset
//   core_hold                  keep fetch/PC logic in reset
//   ce, pc                     fetch request (byte address)
//   inst, inst_valid, inst_err registered fetch response
module inst_rom
  import riscv_pkg::*;
#(
  parameter int unsigned DEPTH     = 256,
  parameter int unsigned AW        = 8,
  parameter bit          BOOT_LOAD = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [31:0]   load_data,
  input  logic          load_last,
  output logic          load_ready,
  output logic [AW:0]   load_count,
  output logic          core_hold,
  input  logic          ce,
  input  logic [31:0]   pc,
  output logic [31:0]   inst,
  output logic          inst_valid,
  output logic          inst_err
);

  localparam rom_state_t  RESET_STATE = BOOT_LOAD ? LOAD : RUN;
  localparam logic [AW-1:0] WPTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] WPTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW:0]   CNT_ONE   = {{AW{1'b0}}, 1'b1};

  rom_state_t    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic          hit_q, hit_d;   // response carries array data
  logic [31:0]   ram_rdata;

  logic accept;
  logic bad_addr;
  logic fetch;

  assign accept   = (state_q == LOAD) && load_valid;
  assign fetch    = (state_q == RUN) && ce;
  assign bad_addr = (|pc[1:0]) || (|pc[31:AW+2]);

  always_comb begin
    state_d = state_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (accept) begin
      wptr_d  = wptr_q + WPTR_ONE;
      count_d = count_q + CNT_ONE;
      // The last array slot ends loading even without load_last: no wrap.
      if (load_last || (wptr_q == WPTR_LAST)) begin
        state_d = RUN;
      end
    end
    valid_d = fetch;
    err_d   = fetch && bad_addr;
    hit_d   = fetch && !bad_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= RESET_STATE;
      wptr_q  <= '0;
      count_q <= '0;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
      hit_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      valid_q <= valid_d;
      err_q   <= err_d;
      hit_q   <= hit_d;
    end
  end

  inst_ram #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_ram (
    .clk  (clk),
    .we   (accept),
    .waddr(wptr_q),
    .wdata(load_data),
    .raddr(pc[AW+1:2]),
    .rdata(ram_rdata)
  );

  // rst is folded in so the core stays held while reset is asserted.
  assign load_ready = (state_q == LOAD) && !rst;
  assign core_hold  = (state_q == LOAD) || rst;
  assign load_count = count_q;
  assign inst_valid = valid_q;
  assign inst_err   = err_q;
  // The RAM output register is the data register; hit_q only selects NOP.
  assign inst       = hit_q ? ram_rdata : NOP_INST;

endmodule

// File: doc/inst_rom.md
# inst_rom

Instruction-side responder for the core's fetch path: it answers each `pc`/`ce` request from the program-counter register with the 32-bit instruction word one clock later. It also owns boot-time program loading. After reset it accepts a stream of words into its array while holding the core in reset, then switches to run mode and serves fetches. It sits between the external loader (UART/debug bridge) and the fetch/decode stage.

## Interface
- `DEPTH`, 256, number of 32-bit words in the array (power of two, ≥4)
- `AW`, 8, word-address width, equal to log2(`DEPTH`)
- `BOOT_LOAD`, 1, 1 = start in LOAD after reset; 0 = start directly in RUN
- `clk`  in  1  single clock for the whole block
- `rst`  in  1  asynchronous, active-high reset
- `load_valid`  in  1  loader word present
- `load_data`  in  32  loader word
- `load_last`  in  1  qualifies the final word of the program
- `load_ready`  out  1  block accepts a loader word this cycle
- `load_count`  out  AW+1  number of words written since reset
- `core_hold`  out  1  high = keep the fetch/PC logic in reset
- `ce`  in  1  fetch enable from the PC register
- `pc`  in  32  byte address of the fetch
- `inst`  out  32  fetched instruction
- `inst_valid`  out  1  `inst` holds a real fetch result
- `inst_err`  out  1  last fetch was misaligned or out of range

## Operation
- States: LOAD and RUN. Reset enters LOAD if `BOOT_LOAD`=1, otherwise RUN.
- LOAD:
  - `load_ready`=1 and `core_hold`=1.
  - A beat is accepted when `load_valid & load_ready`. The word is written at `wptr`, then `wptr` and `load_count` increment.
  - An accepted beat with `load_last`=1 moves the FSM to RUN.
  - An accepted beat at `wptr`=`DEPTH`-1 also moves the FSM to RUN, whether or not `load_last` is set. No wrap, no overwrite.
- RUN:
  - `load_ready`=0 and `core_hold`=0. Loader beats are ignored.
  - The array is never written in RUN.
- Fetch (RUN only):
  - If `ce`=1, the word address is `pc[AW+1:2]`.
  - Misaligned fetch (`pc[1:0]`≠0) or out-of-range fetch (`pc[31:AW+2]`≠0): `inst`=NOP 0x00000013, `inst_err`=1, `inst_valid`=1.
  - If `ce`=0, or in LOAD: `inst`=NOP, `inst_valid`=0, `inst_err`=0.
- Simultaneous `load_valid`/`load_last` with the counter at `DEPTH`-1: a single write occurs, then RUN.
- Reset mid-load or mid-run returns to the reset state and clears `wptr` and `load_count`. Array contents are not cleared.
- A `load_last` beat with `load_valid`=0 has no effect.

## Timing
- Reset values: `inst`=0x00000013, `inst_valid`=0, `inst_err`=0, `load_count`=0.
- During reset, `load_ready`=0 and `core_hold`=1 regardless of `BOOT_LOAD`.
- Write: data is in the array at the clock edge that accepts the beat.
- LOAD→RUN: `core_hold` and `load_ready` fall in the cycle after the final beat is accepted.
- Fetch latency is exactly 1 cycle: `pc`/`ce` sampled at edge n drive `inst`/`inst_valid`/`inst_err` after edge n. All three outputs are registered.
- Back-to-back fetches sustain one per cycle, with no stall and no backpressure.
- The first RUN cycle may fetch word 0 immediately.

## Structure
- Shared package `riscv_pkg`: `NOP_INST` constant 32'h00000013 and the state enum `rom_state_t` {LOAD, RUN}. The opcode constants already consumed by the PC register also move there.
- One sub-module, `inst_ram`: a `DEPTH`×32 array with one synchronous write port and one synchronous read port. It has no reset, so it infers block RAM.
- `inst_rom` holds the FSM, write pointer, address/range check and output registers.

## Test plan
- Load 0x00000013, 0x00100093, 0x00208113 with `load_last` on the third beat. Expect `load_count`=3 and `core_hold` falling 1 cycle later. Then `pc`=0,4,8 on consecutive cycles → `inst` gives those three words in order, each 1 cycle after its `pc`, with `inst_valid`=1.
- Feed `DEPTH` beats with no `load_last` → RUN entered after beat `DEPTH`-1. A further `load_valid` is ignored and word 0 is unchanged.
- In RUN, `pc`=0x2 → `inst`=0x00000013, `inst_err`=1. `pc`=4·`DEPTH` → `inst_err`=1. Next `pc`=0 → `inst_err`=0.
- `ce`=0 in RUN with any `pc` → `inst_valid`=0 and `inst`=NOP.
- Assert `rst` after 5 loaded words → `load_count`=0, `core_hold`=1, outputs at reset values. Reload 1 word with `load_last`; `pc`=4 returns the pre-reset word 1 (array retained).
- `BOOT_LOAD`=0 → after reset `core_hold`=0 and `load_ready`=0 from the first cycle, and fetches are served immediately.
